// File: rtl/key_date_ctrl_if.sv
// rtl/key_date_ctrl_if.sv - key/switch inputs and LED/display outputs of key_date_ctrl
interface key_date_ctrl_if;
   logic [1:0]  key_n;
   logic [9:0]  switch;
   logic [9:0]  leds;
   logic [23:0] digits;
   logic        date_sel;
   logic        invert;
   logic [1:0]  press;

   modport master (
      output key_n, switch,
      input  leds, digits, date_sel, invert, press
   );

   modport slave (
      input  key_n, switch,
      output leds, digits, date_sel, invert, press
   );
endinterface

// File: rtl/key_date_ctrl.sv
// rtl/key_date_ctrl.sv - key synchronize/debounce, press pulses, LED invert and date select
module key_date_ctrl #(
   parameter int          DEBOUNCE_CYCLES = 500000,
   parameter logic [23:0] DATE_A          = 24'h082301,
   parameter logic [23:0] DATE_B          = 24'h082401
) (
   input logic            clk,
   input logic            reset,
   key_date_ctrl_if.slave bus
);
   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {STABLE_HI, CHK_LO, STABLE_LO, CHK_HI} deb_state_t;

   logic [1:0]    sync1, sync2;
   deb_state_t    state     [2];
   deb_state_t    state_nxt [2];
   logic [CW-1:0] cnt       [2];
   logic [CW-1:0] cnt_nxt   [2];
   logic [1:0]    press_q, press_nxt;
   logic          invert_q, invert_nxt;
   logic          date_sel_q, date_sel_nxt;
   logic [9:0]    leds_q;
   logic [23:0]   digits_q;
   logic          unused_switch;

   assign unused_switch = ^bus.switch[9:8];

   // Registered press pulses toggle one edge later; LEDs and digits follow the new values.
   assign invert_nxt   = invert_q ^ press_q[0];
   assign date_sel_nxt = date_sel_q ^ press_q[1];

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         press_nxt[i] = 1'b0;
         case (state[i])
            STABLE_HI: begin
               if (!sync2[i]) begin
                  state_nxt[i] = CHK_LO;
                  cnt_nxt[i]   = CNT_ONE;
               end
            end
            CHK_LO: begin
               if (sync2[i]) begin
                  state_nxt[i] = STABLE_HI;
                  cnt_nxt[i]   = '0;
               end else if (cnt[i] == CNT_MAX) begin
                  state_nxt[i] = STABLE_LO;
                  cnt_nxt[i]   = '0;
                  press_nxt[i] = 1'b1;
               end else begin
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
               end
            end
            STABLE_LO: begin
               if (sync2[i]) begin
                  state_nxt[i] = CHK_HI;
                  cnt_nxt[i]   = CNT_ONE;
               end
            end
            CHK_HI: begin
               if (!sync2[i]) begin
                  state_nxt[i] = STABLE_LO;
                  cnt_nxt[i]   = '0;
               end else if (cnt[i] == CNT_MAX) begin
                  state_nxt[i] = STABLE_HI;
                  cnt_nxt[i]   = '0;
               end else begin
                  cnt_nxt[i] = cnt[i] + CNT_ONE;
               end
            end
            default: begin
               state_nxt[i] = STABLE_HI;
               cnt_nxt[i]   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= 2'b11;
         sync2      <= 2'b11;
         for (int i = 0; i < 2; i++) begin
            state[i] <= STABLE_HI;
            cnt[i]   <= '0;
         end
         press_q    <= 2'b00;
         invert_q   <= 1'b0;
         date_sel_q <= 1'b0;
         leds_q     <= '0;
         digits_q   <= DATE_A;
      end else begin
         sync1      <= bus.key_n;
         sync2      <= sync1;
         for (int i = 0; i < 2; i++) begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
         press_q    <= press_nxt;
         invert_q   <= invert_nxt;
         date_sel_q <= date_sel_nxt;
         leds_q     <= {2'b00, invert_nxt ? ~bus.switch[7:0] : bus.switch[7:0]};
         digits_q   <= date_sel_nxt ? DATE_B : DATE_A;
      end
   end

   assign bus.leds     = leds_q;
   assign bus.digits   = digits_q;
   assign bus.date_sel = date_sel_q;
   assign bus.invert   = invert_q;
   assign bus.press    = press_q;
endmodule

// File: doc/key_date_ctrl.md
Name: key_date_ctrl

Overview:
Upstream control stage for the board's switch/LED/seven-segment display path. Synchronizes and debounces the two active-low push-buttons, then turns each clean press into a one-cycle pulse. KEY0 presses toggle LED inversion. KEY1 presses toggle which of two 6-digit dates is presented to the six sevenSeg decoders (hex5..hex0). Registered LED drive and the 24-bit digit bus replace the level-sensitive key logic in the board top.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a key level change (10 ms at 50 MHz); legal range >= 1
DATE_A, 24'h082301, digits hex5..hex0 shown when date_sel=0, one 4-bit BCD nibble per display
DATE_B, 24'h082401, digits hex5..hex0 shown when date_sel=1

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
key_n  in  2  raw push-buttons, active-low (0 = pressed), asynchronous to clk
switch  in  10  slide switches, quasi-static
leds  out  10  LED drive; [9:8] always 0
digits  out  24  [23:20]=hex5 … [3:0]=hex0 nibble, to sevenSeg val inputs
date_sel  out  1  0 = DATE_A shown, 1 = DATE_B shown
invert  out  1  1 = leds[7:0] show ~switch[7:0]
press  out  2  one-cycle pulse per accepted press, bit i for key i

Behaviour:
- Reset (sync, highest priority): sync flops=1, stable level=1 (released), debounce counters=0, press=0, date_sel=0, invert=0, leds=0, digits=DATE_A.
- Per key i, independent identical logic:
  - Synchronizer: 2-flop on key_n[i].
  - Debounce FSM, states STABLE_HI, CHK_LO, STABLE_LO, CHK_HI.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - In STABLE_x, a synced level differing from the stable level moves to CHK_x with counter=1.
  - In CHK_x, a differing sample increments the counter. A matching sample (bounce) returns to STABLE_x with counter=0.
  - When the counter reaches DEBOUNCE_CYCLES, the FSM enters the opposite STABLE state and the counter clears.
  - press[i]=1 for exactly the one cycle after the CHK_LO→STABLE_LO transition. Release (→STABLE_HI) produces no pulse.
- Latency: let edge 0 be the first edge sampling key_n[i]=0. The synced low appears after edge 1. press[i] is high in the cycle after edge DEBOUNCE_CYCLES+2. The toggle takes effect at the following edge.
- Toggles: press[0] → invert <= ~invert. press[1] → date_sel <= ~date_sel.
- digits: registered, updated at the same edge as date_sel, = (next date_sel ? DATE_B : DATE_A).
- leds: registered every cycle.
  - leds[7:0] <= (next invert) ? ~switch[7:0] : switch[7:0], so there is 1 cycle of switch→LED latency.
  - leds[9:8] <= 0.
- Simultaneous events: both keys may pulse in the same cycle, and both toggles apply in the same edge. Holding a key produces one pulse only, with no auto-repeat.
- Reset mid-debounce: the in-progress count is discarded and no pulse is issued. A key still held when reset deasserts is debounced afresh as a new press (pulse after DEBOUNCE_CYCLES+2 edges).
- Counter never wraps: it is bounded by DEBOUNCE_CYCLES and cleared on every state exit.

Test Plan:
- Reset with DEBOUNCE_CYCLES=4, switch=10'h0A5, keys released → after 1 edge: leds=10'h0A5, digits=24'h082301, date_sel=0, invert=0, press=0.
- Clean KEY1 press, held 20 cycles → press[1] high exactly 1 cycle at cycle 7 after first low sample. date_sel=1 and digits=24'h082401 from next cycle. Release → no pulse, values held.
- KEY0 bounce: low 3 cycles, high 1, low 3, high → no press[0], invert stays 0. Then low 10 cycles → one pulse, leds=10'h05A with switch=10'h0A5.
- Both keys pressed in the same cycle → press=2'b11 for one cycle. invert and date_sel both toggle on the same edge.
- KEY1 held across a reset asserted mid-count (cycle 3) → no pulse before reset, date_sel=0 after reset. One pulse 6 edges after reset deasserts, date_sel=1.
- Second KEY1 press after release → date_sel returns to 0, digits=24'h082301. Verifies toggle wrap back to DATE_A.
